td4_uart_loader: RTL and testbench
==================================

Name: td4_uart_loader

Overview:
- Serial program loader that sits directly upstream of the TD4 instruction memory.
- Receives 8N1 UART bytes on one pin, splits each byte into a 4-bit opcode and a 4-bit immediate, and issues single-cycle write strobes to the 16-entry memory at auto-incrementing addresses.
- Replaces 16 manual pin-driven load operations with one host serial download.
- Active only while the top level holds the design in load mode (`enable`); idle while the CPU executes.

Parameters:
- CLKS_PER_BIT, 434, clk cycles per UART bit (must be >= 4; even values recommended).
- MEM_DEPTH, 16, number of memory words to load before `done`.

Ports:
- clk  in  1  system clock
- rst_n  in  1  asynchronous active-low reset
- enable  in  1  1 = loader listens on rx; 0 = rx ignored, FSM forced to IDLE at the next edge
- arm  in  1  single-cycle pulse: restart load at address 0, clear done/frame_error
- rx  in  1  UART receive line, idle high, asynchronous to clk
- mem_address  out  4  write address to memory
- opcode_out  out  4  opcode nibble (byte bits [3:0])
- immediate_out  out  4  immediate nibble (byte bits [7:4])
- mem_write  out  1  active-high write strobe, exactly one clk wide
- busy  out  1  1 while a frame is in progress (states other than IDLE)
- done  out  1  sticky; set when MEM_DEPTH words have been written
- frame_error  out  1  sticky; set on a bad stop bit (or bad parity, see Optional Feature)

Behaviour:
- Reset: all outputs 0. FSM = IDLE. Bit/clock counters = 0. Synchronizer flops = 1 (idle line).
- rx passes through a 2-flop synchronizer before use. All timing below is measured from the synchronized signal.
- FSM states:
  - IDLE -> START: on a synchronized falling edge of rx, with enable=1.
  - START: wait CLKS_PER_BIT/2 cycles, then sample. If 0 -> DATA. If 1 -> IDLE (glitch rejected; nothing written).
  - DATA: sample every CLKS_PER_BIT cycles, 8 bits, LSB first, into a shift register. After bit 7 -> STOP.
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample = 1: valid byte -> WRITE.
    - Sample = 0: set frame_error, discard the byte -> WAIT_IDLE.
  - WRITE: lasts one cycle. mem_write=1, mem_address=addr_cnt, opcode_out=byte[3:0], immediate_out=byte[7:4]. Then addr_cnt increments, FSM -> IDLE.
  - WAIT_IDLE: stay until synchronized rx=1, then -> IDLE.
- Output latency: the mem_write pulse occurs in the cycle after the stop-bit sample.
- opcode_out and immediate_out hold their last values between strobes. mem_address shows addr_cnt at all times.
- addr_cnt is 4 bits wide:
  - After the write to address MEM_DEPTH-1, addr_cnt wraps to 0 and done is set in the same cycle.
  - While done=1, received frames are parsed but produce no mem_write and no address change.
- arm:
  - Clears addr_cnt, done and frame_error.
  - Aborts any frame in progress: FSM -> WAIT_IDLE if rx=0, else IDLE.
  - arm coincident with WRITE: arm wins. No strobe is issued; addr_cnt = 0.
- enable deasserted mid-frame: frame aborted, no write. addr_cnt, done and frame_error are retained.
- frame_error does not block later frames. Loading continues at the unchanged address.

Optional Feature:
- Macro: LOADER_PARITY_EN.
- When defined:
  - A PARITY state is inserted between DATA and STOP, giving a 9-bit frame (8E1, even parity).
  - On parity mismatch: frame_error is set, the stop bit is still sampled, no write is issued, and the FSM goes to WAIT_IDLE if the stop bit is 0, else IDLE.
- When undefined: plain 8N1. The PARITY state and parity logic are absent.

Decomposition:
- Package td4_pkg holds:
  - loader FSM state enum: IDLE, START, DATA, PARITY, STOP, WRITE, WAIT_IDLE.
  - ADDR_W=4, NIBBLE_W=4, MEM_WORDS=16.
- Natural sub-module: td4_uart_rx, containing the synchronizer, bit timing and shift register. It outputs a byte_valid pulse plus byte and err flags.
- td4_uart_loader keeps the address counter, done/arm logic and memory-side outputs.

Test Plan:
All scenarios use CLKS_PER_BIT=4 and enable=1.
1. arm pulse, then send 0x3B -> exactly one mem_write, with mem_address=0, opcode_out=0xB, immediate_out=0x3; afterwards mem_address=1.
2. arm, then send bytes 0x10..0x1F -> 16 strobes at addresses 0..15 with opcode = low nibble; done=1 after the 16th. A 17th byte 0xFF produces no mem_write and mem_address stays 0.
3. Send 0x55 with stop bit driven 0 -> frame_error=1, no mem_write, mem_address unchanged. A following valid 0x21 writes to the same address.
4. Drive rx low for 1 clk only -> busy pulses at most CLKS_PER_BIT/2+1 cycles, no write, frame_error=0.
5. Start byte 0x77; pulse arm during data bit 3; then send 0x42 -> no write for 0x77, and 0x42 writes at address 0.
6. With LOADER_PARITY_EN defined, send 0x03 with parity bit 1 -> frame_error=1, no write. Send 0x03 with parity bit 0 -> write with opcode 0x3, immediate 0x0.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared types and constants for the TD4 serial program loader.
// Latency: n/a (declarations only).
// Backpressure: n/a. Optional parity support is selected with LOADER_PARITY_EN.
package td4_pkg;

  localparam int ADDR_W    = 4;
  localparam int NIBBLE_W  = 4;
  localparam int MEM_WORDS = 16;

  // PARITY is only reachable when LOADER_PARITY_EN is defined.
  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WRITE,
    WAIT_IDLE
  } loader_state_t;

  // Even-parity bit that makes the total count of ones in {data, bit} even.
  function automatic logic even_parity(input logic [7:0] data);
    return ^data;
  endfunction

endpackage

// File: rtl/td4_uart_loader_if.sv
// Memory-side write port of the loader towards the TD4 instruction memory.
// Latency: n/a (wires only).
// Backpressure: none; the memory must accept every single-cycle write strobe.
interface td4_uart_loader_if;
  import td4_pkg::*;

  logic [ADDR_W-1:0]   mem_address;
  logic [NIBBLE_W-1:0] opcode_out;
  logic [NIBBLE_W-1:0] immediate_out;
  logic                mem_write;

  modport master (
    output mem_address,
    output opcode_out,
    output immediate_out,
    output mem_write
  );

  modport slave (
    input mem_address,
    input opcode_out,
    input immediate_out,
    input mem_write
  );

endinterface

// File: rtl/td4_uart_rx.sv
// UART receiver (8N1, or 8E1 with LOADER_PARITY_EN): synchronizer, bit timing, shift register.
// Latency: byte_valid asserts in the cycle after the stop-bit sample (WRITE state).
// Backpressure: none; byte_valid is a one-cycle pulse, suppressed by abort or enable=0.
module td4_uart_rx
  import td4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       enable,
  input  logic       abort,
  input  logic       rx,
  output logic       byte_valid,
  output logic [7:0] byte_dat,
  output logic       byte_err,
  output logic       busy
);

  localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  logic          rx_s1, rx_s2, rx_d;
  logic          rx_fall;
  loader_state_t state_q, state_nxt;
  logic [CW-1:0] clk_cnt_q, clk_cnt_nxt;
  logic [2:0]    bit_cnt_q, bit_cnt_nxt;
  logic [7:0]    shift_q, shift_nxt;
`ifdef LOADER_PARITY_EN
  logic          par_err_q, par_err_nxt;
`endif

  // Two-flop synchronizer plus one delay flop for falling-edge detection; idle line is high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1 <= 1'b1;
      rx_s2 <= 1'b1;
      rx_d  <= 1'b1;
    end else begin
      rx_s1 <= rx;
      rx_s2 <= rx_s1;
      rx_d  <= rx_s2;
    end
  end

  assign rx_fall = rx_d & ~rx_s2;

  // State and datapath registers of the receive FSM.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      clk_cnt_q <= '0;
      bit_cnt_q <= '0;
      shift_q   <= '0;
`ifdef LOADER_PARITY_EN
      par_err_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_nxt;
      clk_cnt_q <= clk_cnt_nxt;
      bit_cnt_q <= bit_cnt_nxt;
      shift_q   <= shift_nxt;
`ifdef LOADER_PARITY_EN
      par_err_q <= par_err_nxt;
`endif
    end
  end

  // Next-state, bit timing and result pulses; enable and abort override everything.
  always_comb begin
    state_nxt   = state_q;
    clk_cnt_nxt = clk_cnt_q;
    bit_cnt_nxt = bit_cnt_q;
    shift_nxt   = shift_q;
    byte_valid  = 1'b0;
    byte_err    = 1'b0;
`ifdef LOADER_PARITY_EN
    par_err_nxt = par_err_q;
`endif

    case (state_q)
      IDLE: begin
        if (rx_fall) begin
          state_nxt   = START;
          clk_cnt_nxt = '0;
        end
      end

      START: begin
        if (clk_cnt_q == HALF_LAST) begin
          clk_cnt_nxt = '0;
          bit_cnt_nxt = '0;
          // A line back high at mid start bit was a glitch.
          state_nxt   = rx_s2 ? IDLE : DATA;
        end else begin
          clk_cnt_nxt = clk_cnt_q + CW'(1);
        end
      end

      DATA: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_nxt = '0;
          shift_nxt   = {rx_s2, shift_q[7:1]};
          bit_cnt_nxt = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) begin
`ifdef LOADER_PARITY_EN
            state_nxt = PARITY;
`else
            state_nxt = STOP;
`endif
          end
        end else begin
          clk_cnt_nxt = clk_cnt_q + CW'(1);
        end
      end

`ifdef LOADER_PARITY_EN
      PARITY: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_nxt = '0;
          par_err_nxt = even_parity(shift_q) ^ rx_s2;
          state_nxt   = STOP;
        end else begin
          clk_cnt_nxt = clk_cnt_q + CW'(1);
        end
      end
`endif

      STOP: begin
        if (clk_cnt_q == BIT_LAST) begin
          clk_cnt_nxt = '0;
          if (!rx_s2) begin
            // Line still low: wait for it to return high before hunting a new start bit.
            byte_err  = 1'b1;
            state_nxt = WAIT_IDLE;
`ifdef LOADER_PARITY_EN
          end else if (par_err_q) begin
            byte_err  = 1'b1;
            state_nxt = IDLE;
`endif
          end else begin
            state_nxt = WRITE;
          end
        end else begin
          clk_cnt_nxt = clk_cnt_q + CW'(1);
        end
      end

      WRITE: begin
        byte_valid = 1'b1;
        state_nxt  = IDLE;
      end

      WAIT_IDLE: begin
        if (rx_s2) begin
          state_nxt = IDLE;
        end
      end

      default: begin
        state_nxt = IDLE;
      end
    endcase

    if (!enable) begin
      state_nxt  = IDLE;
      byte_valid = 1'b0;
      byte_err   = 1'b0;
    end else if (abort) begin
      state_nxt  = rx_s2 ? IDLE : WAIT_IDLE;
      byte_valid = 1'b0;
      byte_err   = 1'b0;
    end
  end

  assign byte_dat = shift_q;
  assign busy     = (state_q != IDLE);

endmodule

// File: rtl/td4_uart_loader.sv
// Serial program loader: UART bytes -> {immediate, opcode} writes at auto-incrementing addresses.
// Latency: mem_write pulses one cycle after the stop-bit sample; LOADER_PARITY_EN selects 8E1.
// Backpressure: none; frames arriving after done are parsed and dropped, arm restarts the load.
module td4_uart_loader
  import td4_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434,
  parameter int MEM_DEPTH    = MEM_WORDS
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               enable,
  input  logic               arm,
  input  logic               rx,
  td4_uart_loader_if.master  mem,
  output logic               busy,
  output logic               done,
  output logic               frame_error
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(MEM_DEPTH - 1);

  logic                rx_byte_vld;
  logic [7:0]          rx_byte_dat;
  logic                rx_byte_err;
  logic                wr_en;
  logic [ADDR_W-1:0]   addr_cnt;
  logic                done_q;
  logic                ferr_q;
  logic [NIBBLE_W-1:0] opc_q;
  logic [NIBBLE_W-1:0] imm_q;

  td4_uart_rx #(
    .CLKS_PER_BIT (CLKS_PER_BIT)
  ) u_rx (
    .clk        (clk),
    .rst_n      (rst_n),
    .enable     (enable),
    .abort      (arm),
    .rx         (rx),
    .byte_valid (rx_byte_vld),
    .byte_dat   (rx_byte_dat),
    .byte_err   (rx_byte_err),
    .busy       (busy)
  );

  // Once the memory is full, further bytes are parsed but never written.
  assign wr_en = rx_byte_vld & ~done_q;

  // Address counter, sticky status flags and held nibbles; arm has priority over everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_cnt <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
      opc_q    <= '0;
      imm_q    <= '0;
    end else if (arm) begin
      addr_cnt <= '0;
      done_q   <= 1'b0;
      ferr_q   <= 1'b0;
    end else begin
      if (rx_byte_err) begin
        ferr_q <= 1'b1;
      end
      if (wr_en) begin
        opc_q <= rx_byte_dat[3:0];
        imm_q <= rx_byte_dat[7:4];
        if (addr_cnt == LAST_ADDR) begin
          addr_cnt <= '0;
          done_q   <= 1'b1;
        end else begin
          addr_cnt <= addr_cnt + ADDR_W'(1);
        end
      end
    end
  end

  // Nibbles are presented during the strobe and held afterwards.
  assign mem.mem_write     = wr_en;
  assign mem.mem_address   = addr_cnt;
  assign mem.opcode_out    = wr_en ? rx_byte_dat[3:0] : opc_q;
  assign mem.immediate_out = wr_en ? rx_byte_dat[7:4] : imm_q;
  assign done              = done_q;
  assign frame_error       = ferr_q;

endmodule

// File: tb/tb_td4_uart_loader.sv
// Directed bench for td4_uart_loader with CLKS_PER_BIT=4.
// Latency: writes are expected within the idle gap that follows each frame.
// Backpressure: n/a; define LOADER_PARITY_EN to include the parity scenario.
module tb_td4_uart_loader;
  import td4_pkg::*;

  localparam int CPB = 4;

  logic clk = 1'b0;
  logic rst_n;
  logic enable;
  logic arm;
  logic rx;
  logic busy;
  logic done;
  logic frame_error;

  int errors = 0;
  int checks = 0;

  int         wr_cnt = 0;
  logic [3:0] wa [64];
  logic [3:0] wo [64];
  logic [3:0] wi [64];

`ifdef LOADER_PARITY_EN
  logic par_flip = 1'b0;
`endif

  td4_uart_loader_if mem ();

  td4_uart_loader #(
    .CLKS_PER_BIT (CPB),
    .MEM_DEPTH    (16)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .enable      (enable),
    .arm         (arm),
    .rx          (rx),
    .mem         (mem),
    .busy        (busy),
    .done        (done),
    .frame_error (frame_error)
  );

  always #5 clk = ~clk;

  // Record every write strobe seen on the memory port.
  always @(negedge clk) begin
    if (mem.mem_write === 1'b1) begin
      if (wr_cnt < 64) begin
        wa[wr_cnt] <= mem.mem_address;
        wo[wr_cnt] <= mem.opcode_out;
        wi[wr_cnt] <= mem.immediate_out;
      end
      wr_cnt <= wr_cnt + 1;
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_clks(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic pulse_arm();
    arm = 1'b1;
    wait_clks(1);
    arm = 1'b0;
    wait_clks(1);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
`ifdef LOADER_PARITY_EN
    rx = (^b) ^ par_flip;
    wait_clks(CPB);
`endif
    rx = stop_bit;
    wait_clks(CPB);
    rx = 1'b1;
    wait_clks(3 * CPB);
  endtask

  initial begin
    int base;
    int busy_cnt;
    logic [7:0] b;

    rst_n  = 1'b0;
    enable = 1'b1;
    arm    = 1'b0;
    rx     = 1'b1;
    wait_clks(3);
    chk("rst_addr", 32'(mem.mem_address), 32'h0);
    chk("rst_wr", 32'(mem.mem_write), 32'h0);
    chk("rst_opc", 32'(mem.opcode_out), 32'h0);
    chk("rst_imm", 32'(mem.immediate_out), 32'h0);
    chk("rst_busy", 32'(busy), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    chk("rst_ferr", 32'(frame_error), 32'h0);
    rst_n = 1'b1;
    wait_clks(2);

    // Single byte 0x3B
    pulse_arm();
    base = wr_cnt;
    send_byte(8'h3B, 1'b1);
    chk("s1_wrcnt", 32'(wr_cnt - base), 32'd1);
    chk("s1_addr", 32'(wa[base]), 32'h0);
    chk("s1_opc", 32'(wo[base]), 32'hB);
    chk("s1_imm", 32'(wi[base]), 32'h3);
    chk("s1_addr_after", 32'(mem.mem_address), 32'h1);
    chk("s1_opc_hold", 32'(mem.opcode_out), 32'hB);
    chk("s1_busy", 32'(busy), 32'h0);

    // Full 16-word load, then one extra byte
    pulse_arm();
    chk("s2_arm_addr", 32'(mem.mem_address), 32'h0);
    base = wr_cnt;
    for (int i = 0; i < 16; i++) begin
      b = 8'h10 + 8'(i);
      send_byte(b, 1'b1);
      if (i == 14) chk("s2_done_early", 32'(done), 32'h0);
    end
    chk("s2_wrcnt", 32'(wr_cnt - base), 32'd16);
    for (int i = 0; i < 16; i++) begin
      chk($sformatf("s2_addr%0d", i), 32'(wa[base + i]), 32'(i));
      chk($sformatf("s2_opc%0d", i), 32'(wo[base + i]), 32'(i));
      chk($sformatf("s2_imm%0d", i), 32'(wi[base + i]), 32'h1);
    end
    chk("s2_done", 32'(done), 32'h1);
    chk("s2_addr_wrap", 32'(mem.mem_address), 32'h0);
    base = wr_cnt;
    send_byte(8'hFF, 1'b1);
    chk("s2_extra_wrcnt", 32'(wr_cnt - base), 32'd0);
    chk("s2_extra_addr", 32'(mem.mem_address), 32'h0);
    chk("s2_extra_imm", 32'(mem.immediate_out), 32'h1);
    chk("s2_extra_done", 32'(done), 32'h1);

    // Bad stop bit, then a good byte at the same address
    pulse_arm();
    chk("s3_arm_done", 32'(done), 32'h0);
    send_byte(8'h10, 1'b1);
    chk("s3_pre_addr", 32'(mem.mem_address), 32'h1);
    base = wr_cnt;
    send_byte(8'h55, 1'b0);
    chk("s3_ferr", 32'(frame_error), 32'h1);
    chk("s3_bad_wrcnt", 32'(wr_cnt - base), 32'd0);
    chk("s3_bad_addr", 32'(mem.mem_address), 32'h1);
    chk("s3_bad_busy", 32'(busy), 32'h0);
    send_byte(8'h21, 1'b1);
    chk("s3_good_wrcnt", 32'(wr_cnt - base), 32'd1);
    chk("s3_good_addr", 32'(wa[base]), 32'h1);
    chk("s3_good_opc", 32'(wo[base]), 32'h1);
    chk("s3_good_imm", 32'(wi[base]), 32'h2);
    chk("s3_ferr_sticky", 32'(frame_error), 32'h1);

    // One-cycle glitch on rx
    pulse_arm();
    chk("s4_arm_ferr", 32'(frame_error), 32'h0);
    base = wr_cnt;
    busy_cnt = 0;
    rx = 1'b0;
    wait_clks(1);
    rx = 1'b1;
    for (int i = 0; i < 12; i++) begin
      wait_clks(1);
      if (busy === 1'b1) busy_cnt++;
    end
    chk("s4_busy_bound", 32'(busy_cnt <= CPB / 2 + 1), 32'h1);
    chk("s4_wrcnt", 32'(wr_cnt - base), 32'd0);
    chk("s4_ferr", 32'(frame_error), 32'h0);
    chk("s4_addr", 32'(mem.mem_address), 32'h0);

    // arm during data bit 3 of 0x77, then 0x42
    send_byte(8'h66, 1'b1);
    chk("s5_pre_addr", 32'(mem.mem_address), 32'h1);
    base = wr_cnt;
    b = 8'h77;
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 3; i++) begin
      rx = b[i];
      wait_clks(CPB);
    end
    rx = b[3];
    wait_clks(CPB - 1);
    chk("s5_busy_mid", 32'(busy), 32'h1);
    arm = 1'b1;
    wait_clks(1);
    arm = 1'b0;
    rx = 1'b1;
    wait_clks(3 * CPB);
    chk("s5_abort_wrcnt", 32'(wr_cnt - base), 32'd0);
    chk("s5_abort_addr", 32'(mem.mem_address), 32'h0);
    chk("s5_abort_busy", 32'(busy), 32'h0);
    send_byte(8'h42, 1'b1);
    chk("s5_wrcnt", 32'(wr_cnt - base), 32'd1);
    chk("s5_addr", 32'(wa[base]), 32'h0);
    chk("s5_opc", 32'(wo[base]), 32'h2);
    chk("s5_imm", 32'(wi[base]), 32'h4);

    // enable dropped mid-frame
    base = wr_cnt;
    b = 8'h5A;
    rx = 1'b0;
    wait_clks(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      if (i == 2) begin
        chk("en_busy_before", 32'(busy), 32'h1);
        enable = 1'b0;
        wait_clks(1);
        chk("en_busy_after", 32'(busy), 32'h0);
        wait_clks(CPB - 1);
      end else begin
        wait_clks(CPB);
      end
    end
    rx = 1'b1;
    wait_clks(2 * CPB);
    enable = 1'b1;
    wait_clks(CPB);
    chk("en_wrcnt", 32'(wr_cnt - base), 32'd0);
    chk("en_addr_kept", 32'(mem.mem_address), 32'h1);

`ifdef LOADER_PARITY_EN
    // Even parity: 0x03 needs parity bit 0
    pulse_arm();
    base = wr_cnt;
    par_flip = 1'b1;
    send_byte(8'h03, 1'b1);
    chk("s6_bad_ferr", 32'(frame_error), 32'h1);
    chk("s6_bad_wrcnt", 32'(wr_cnt - base), 32'd0);
    par_flip = 1'b0;
    send_byte(8'h03, 1'b1);
    chk("s6_good_wrcnt", 32'(wr_cnt - base), 32'd1);
    chk("s6_good_addr", 32'(wa[base]), 32'h0);
    chk("s6_good_opc", 32'(wo[base]), 32'h3);
    chk("s6_good_imm", 32'(wi[base]), 32'h0);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
